pc_pilha: RTL and testbench

- Parametrised next-generation program counter for the fpgmips core.
- Supports sequential increment, absolute jump, PC-relative branch, call/return through an internal return-address stack, stall, and a halt/resume lock.
- Sits at the front of the fetch path and drives the instruction-memory address.
- The halt lock is registered synchronously, not level-sensitive.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pilha_retorno.sv | 63 ++++++
 rtl/pc_pilha.sv | 117 +++++++++++
 tb/tb_pc_pilha.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and types for the pc_pilha program counter and its return-address stack.
package pc_pkg;

    localparam int unsigned PC_WIDTH      = 32;
    localparam int unsigned PC_STEP       = 1;
    localparam int unsigned PC_RESET_ADDR = 0;
    localparam int unsigned RAS_DEPTH     = 8;
    localparam int unsigned PC_OFF_W      = 16;

    // One extra bit so that a full stack (count == depth) is representable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned RAS_PTR_W = ptr_width(RAS_DEPTH);

    typedef enum logic {
        Rodando,
        Parado
    } estado_e;

    typedef enum logic [2:0] {
        OpSegura,
        OpSalto,
        OpChamada,
        OpRetorno,
        OpDesvio,
        OpIncremento
    } op_e;

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO: push/pop with full/empty flags and single-cycle overflow/underflow pulses.
module pilha_retorno
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = RAS_DEPTH
) (
    input  logic             clock,
    input  logic             reseta,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dado,
    output logic [WIDTH-1:0] topo,
    output logic             cheia,
    output logic             vazia,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] cont_q;
    logic [PTR_W-1:0] cont_d;
    logic             faz_push;
    logic             faz_pop;
    logic [IDX_W-1:0] idx_push;
    logic [IDX_W-1:0] idx_topo;

    assign cheia     = (cont_q == PTR_W'(DEPTH));
    assign vazia     = (cont_q == '0);
    assign faz_push  = push && !cheia;
    assign faz_pop   = pop && !vazia;
    assign overflow  = push && cheia;
    assign underflow = pop && vazia;

    assign idx_push = cont_q[IDX_W-1:0];
    assign idx_topo = IDX_W'(cont_q - PTR_W'(1));
    assign topo     = mem_q[idx_topo];

    always_comb begin
        cont_d = cont_q;
        if (faz_push) begin
            cont_d = cont_q + PTR_W'(1);
        end else if (faz_pop) begin
            cont_d = cont_q - PTR_W'(1);
        end
    end

    // Entries are not cleared on reset; the count alone defines validity.
    always_ff @(posedge clock) begin
        if (!reseta) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
            if (faz_push) begin
                mem_q[idx_push] <= dado;
            end
        end
    end

endmodule

// File: rtl/pc_pilha.sv
// Program counter with jump/branch/call/return, stall and a registered halt/resume lock.
module pc_pilha
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH      = PC_WIDTH,
    parameter int unsigned STEP       = PC_STEP,
    parameter int unsigned RESET_ADDR = PC_RESET_ADDR,
    parameter int unsigned DEPTH      = RAS_DEPTH,
    parameter int unsigned OFF_W      = PC_OFF_W
) (
    input  logic             clock,
    input  logic             reseta,
    input  logic             halt,
    input  logic             resume,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] endereco,
    input  logic [OFF_W-1:0] offset,
    output logic [WIDTH-1:0] saida,
    output logic             halted,
    output logic             pilha_vazia,
    output logic             pilha_cheia,
    output logic             erro_pilha
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_mais;
    logic [WIDTH-1:0] alvo_desvio;
    logic [WIDTH-1:0] topo;
    estado_e          estado_q;
    logic             erro_q;
    op_e              op;
    logic             push;
    logic             pop;
    logic             cheia;
    logic             vazia;
    logic             overflow;
    logic             underflow;

    assign pc_mais     = pc_q + WIDTH'(STEP);
    assign alvo_desvio = pc_q + WIDTH'($signed(offset));

    // A halt request in the running state already freezes the PC and the stack.
    always_comb begin
        op = OpIncremento;
        if (estado_q == Parado || halt || stall) begin
            op = OpSegura;
        end else if (jump) begin
            op = OpSalto;
        end else if (call) begin
            op = OpChamada;
        end else if (ret) begin
            op = OpRetorno;
        end else if (branch) begin
            op = OpDesvio;
        end
    end

    assign push = (op == OpChamada);
    assign pop  = (op == OpRetorno);

    always_comb begin
        pc_d = pc_q;
        unique case (op)
            OpSegura:           pc_d = pc_q;
            OpSalto, OpChamada: pc_d = endereco;
            OpRetorno:          pc_d = vazia ? pc_mais : topo;
            OpDesvio:           pc_d = alvo_desvio;
            default:            pc_d = pc_mais;
        endcase
    end

    pilha_retorno #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_pilha (
        .clock    (clock),
        .reseta   (reseta),
        .push     (push),
        .pop      (pop),
        .dado     (pc_mais),
        .topo     (topo),
        .cheia    (cheia),
        .vazia    (vazia),
        .overflow (overflow),
        .underflow(underflow)
    );

    always_ff @(posedge clock) begin
        if (!reseta) begin
            estado_q <= Rodando;
            pc_q     <= WIDTH'(RESET_ADDR);
            erro_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (overflow || underflow) begin
                erro_q <= 1'b1;
            end
            unique case (estado_q)
                Rodando: if (halt) estado_q <= Parado;
                Parado:  if (resume) estado_q <= Rodando;
                default: estado_q <= Rodando;
            endcase
        end
    end

    assign saida       = pc_q;
    assign halted      = (estado_q == Parado);
    assign pilha_vazia = vazia;
    assign pilha_cheia = cheia;
    assign erro_pilha  = erro_q;

endmodule

// File: tb/tb_pc_pilha.sv
// Bench for pc_pilha: a behavioural model queues the expected state per cycle, compared after the edge.
module tb_pc_pilha;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;

    logic         clock = 1'b0;
    logic         reseta, halt, resume, stall, jump, branch, call, ret;
    logic [W-1:0] endereco;
    logic [15:0]  offset;
    logic [W-1:0] saida;
    logic         halted, pilha_vazia, pilha_cheia, erro_pilha;

    always #5 clock = ~clock;

    pc_pilha #(
        .WIDTH     (W),
        .STEP      (1),
        .RESET_ADDR(0),
        .DEPTH     (D),
        .OFF_W     (16)
    ) dut (
        .clock      (clock),
        .reseta     (reseta),
        .halt       (halt),
        .resume     (resume),
        .stall      (stall),
        .jump       (jump),
        .branch     (branch),
        .call       (call),
        .ret        (ret),
        .endereco   (endereco),
        .offset     (offset),
        .saida      (saida),
        .halted     (halted),
        .pilha_vazia(pilha_vazia),
        .pilha_cheia(pilha_cheia),
        .erro_pilha (erro_pilha)
    );

    typedef struct packed {
        logic [W-1:0] pc;
        logic         halted;
        logic         vazia;
        logic         cheia;
        logic         erro;
    } esperado_t;

    esperado_t    fila[$];
    logic [W-1:0] m_pilha[$];
    logic [W-1:0] m_pc;
    logic         m_halted;
    logic         m_erro;
    int           n_checks = 0;
    int           n_falhas = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ocioso();
        reseta   = 1'b1;
        halt     = 1'b0;
        resume   = 1'b0;
        stall    = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        endereco = '0;
        offset   = '0;
    endtask

    // Next state of the architectural PC given the inputs currently driven.
    task automatic modelo();
        if (!reseta) begin
            m_pc     = '0;
            m_halted = 1'b0;
            m_erro   = 1'b0;
            m_pilha.delete();
        end else if (m_halted) begin
            if (resume) m_halted = 1'b0;
        end else if (halt) begin
            m_halted = 1'b1;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (jump) begin
            m_pc = endereco;
        end else if (call) begin
            if (m_pilha.size() == D) m_erro = 1'b1;
            else m_pilha.push_back(m_pc + 1'b1);
            m_pc = endereco;
        end else if (ret) begin
            if (m_pilha.size() == 0) begin
                m_erro = 1'b1;
                m_pc   = m_pc + 1'b1;
            end else begin
                m_pc = m_pilha.pop_back();
            end
        end else if (branch) begin
            m_pc = W'(int'(m_pc) + int'($signed(offset)));
        end else begin
            m_pc = m_pc + 1'b1;
        end
    endtask

    task automatic tick(input string tag);
        esperado_t e;
        modelo();
        e.pc     = m_pc;
        e.halted = m_halted;
        e.vazia  = (m_pilha.size() == 0);
        e.cheia  = (m_pilha.size() == D);
        e.erro   = m_erro;
        fila.push_back(e);
        @(posedge clock);
        #1;
        e = fila.pop_front();
        check_eq({tag, ".pc"}, 32'(saida), 32'(e.pc));
        check_eq({tag, ".halted"}, 32'(halted), 32'(e.halted));
        check_eq({tag, ".vazia"}, 32'(pilha_vazia), 32'(e.vazia));
        check_eq({tag, ".cheia"}, 32'(pilha_cheia), 32'(e.cheia));
        check_eq({tag, ".erro"}, 32'(erro_pilha), 32'(e.erro));
        ocioso();
    endtask

    initial begin
        ocioso();
        reseta = 1'b0;
        tick("reset");
        check_eq("reset_pc", 32'(saida), 32'd0);
        repeat (5) tick("seq");
        check_eq("seq_5", 32'(saida), 32'd5);
        reseta = 1'b0;
        tick("reset_mid");
        check_eq("reset_mid_pc", 32'(saida), 32'd0);

        jump = 1'b1; endereco = 16'd10;
        tick("jump10");
        branch = 1'b1; offset = 16'hFFFD;
        tick("br_neg");
        check_eq("br_neg_pc", 32'(saida), 32'd7);
        jump = 1'b1; endereco = 16'hFFF0;
        tick("jump_fff0");
        branch = 1'b1; offset = 16'h7FFF;
        tick("br_wrap");
        check_eq("br_wrap_pc", 32'(saida), 32'h7FEF);
        jump = 1'b1; endereco = 16'hFFFF;
        tick("jump_ffff");
        tick("inc_wrap");
        check_eq("inc_wrap_pc", 32'(saida), 32'd0);

        jump = 1'b1; endereco = 16'd4;
        tick("jump4");
        call = 1'b1; endereco = 16'd100;
        tick("call100");
        repeat (3) tick("sub_inc");
        check_eq("sub_103", 32'(saida), 32'd103);
        ret = 1'b1;
        tick("ret5");
        check_eq("ret5_pc", 32'(saida), 32'd5);
        check_eq("ret5_vazia", 32'(pilha_vazia), 32'd1);

        for (int i = 0; i < 9; i++) begin
            call = 1'b1; endereco = W'(200 + 16 * i);
            tick("call_n");
        end
        check_eq("ovf_pc", 32'(saida), 32'd328);
        check_eq("ovf_cheia", 32'(pilha_cheia), 32'd1);
        check_eq("ovf_erro", 32'(erro_pilha), 32'd1);
        ret = 1'b1;
        tick("ret_first");
        check_eq("ret_first_pc", 32'(saida), 32'd297);
        for (int i = 0; i < 8; i++) begin
            ret = 1'b1;
            tick("ret_n");
        end
        check_eq("unf_pc", 32'(saida), 32'd7);
        check_eq("unf_erro", 32'(erro_pilha), 32'd1);
        reseta = 1'b0;
        tick("reset_err");
        check_eq("reset_err_clr", 32'(erro_pilha), 32'd0);

        jump = 1'b1; endereco = 16'd20;
        tick("jump20");
        halt = 1'b1;
        tick("halt");
        for (int i = 0; i < 10; i++) begin
            jump = i[0]; call = ~i[0]; ret = 1'b1; branch = 1'b1; stall = i[1];
            endereco = 16'd99; offset = 16'd3;
            tick("halted_hold");
        end
        check_eq("halted_pc20", 32'(saida), 32'd20);
        resume = 1'b1;
        tick("resume");
        check_eq("resume_pc", 32'(saida), 32'd20);
        tick("after_resume");
        check_eq("after_resume_pc", 32'(saida), 32'd21);
        halt = 1'b1;
        tick("halt2");
        halt = 1'b1; resume = 1'b1;
        tick("halt_resume");
        check_eq("halt_resume_h", 32'(halted), 32'd0);
        resume = 1'b1;
        tick("resume_idle");

        jump = 1'b1; endereco = 16'd8;
        tick("jump8");
        stall = 1'b1; jump = 1'b1; endereco = 16'd50;
        tick("stall_jump");
        check_eq("stall_pc", 32'(saida), 32'd8);
        jump = 1'b1; endereco = 16'd50;
        tick("jump50");
        jump = 1'b1; call = 1'b1; endereco = 16'd60;
        tick("jump_call");
        check_eq("jump_call_vazia", 32'(pilha_vazia), 32'd1);
        call = 1'b1; ret = 1'b1; branch = 1'b1; endereco = 16'd70; offset = 16'd5;
        tick("call_ret_br");
        ret = 1'b1;
        tick("ret61");
        check_eq("ret61_pc", 32'(saida), 32'd61);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
        $finish;
    end

endmodule
